// File: rtl/audio_decim_deemph.sv
// Single-pole de-emphasis IIR, decimator and saturating output stage for the
// FM audio path; hands samples to the audio sink over a valid/ready handshake.
module audio_decim_deemph #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC      = 8,
    parameter int SHIFT     = 2,
    parameter int DECIM     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    input  logic signed [WIDTH-1:0]     data_i,
    input  logic                        deemph_en_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        overrun_o,
    input  logic                        overrun_clr_i
);

    localparam int ACC_W = WIDTH + FRAC + 1;
    localparam int Y_W   = ACC_W - FRAC;
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    localparam logic signed [Y_W-1:0] Y_MAX =
        {{(Y_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [Y_W-1:0] Y_MIN = ~Y_MAX;
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic                        pending_q, pending_d;
    logic                        valid_q, valid_d;
    logic signed [OUT_WIDTH-1:0] data_q, data_d;
    logic                        overrun_q, overrun_d;

    logic signed [ACC_W-1:0]     x;
    logic signed [ACC_W-1:0]     diff;
    logic signed [ACC_W-1:0]     step;
    logic signed [Y_W-1:0]       y_full;
    logic signed [OUT_WIDTH-1:0] y_sat;

    // Input promoted to the accumulator's fixed-point grid with guard bits.
    assign x    = $signed({{(FRAC+1){data_i[WIDTH-1]}}, data_i}) <<< FRAC;
    assign diff = x - acc_q;
    assign step = diff >>> SHIFT;

    assign y_full = acc_q[ACC_W-1:FRAC];

    always_comb begin
        y_sat = y_full[OUT_WIDTH-1:0];
        if (y_full > Y_MAX) begin
            y_sat = OUT_MAX;
        end else if (y_full < Y_MIN) begin
            y_sat = OUT_MIN;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        pending_d = 1'b0;
        if (in_valid_i) begin
            acc_d = deemph_en_i ? (acc_q + step) : x;
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A held sample that is not being taken this cycle wins over a new one.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
        if (pending_q) begin
            if (!valid_q || out_ready_i) begin
                valid_d = 1'b1;
                data_d  = y_sat;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_audio_decim_deemph.sv
// Directed and randomized checks of audio_decim_deemph (DECIM=5 and DECIM=1)
// against an arithmetic reference model.
module tb_audio_decim_deemph;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid_i;
    logic signed [31:0] data_i;
    logic               deemph_en_i;
    logic               out_ready_i;
    logic               overrun_clr_i;

    logic               out_valid_5, out_valid_1;
    logic signed [15:0] data_5, data_1;
    logic               overrun_5, overrun_1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    audio_decim_deemph #(.DECIM(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .data_i(data_i),
        .deemph_en_i(deemph_en_i), .out_valid_o(out_valid_5), .out_ready_i(out_ready_i),
        .data_o(data_5), .overrun_o(overrun_5), .overrun_clr_i(overrun_clr_i));

    audio_decim_deemph #(.DECIM(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .data_i(data_i),
        .deemph_en_i(deemph_en_i), .out_valid_o(out_valid_1), .out_ready_i(out_ready_i),
        .data_o(data_1), .overrun_o(overrun_1), .overrun_clr_i(overrun_clr_i));

    // Reference model: index 0 models DECIM=5, index 1 models DECIM=1.
    int     m_decim [2] = '{5, 1};
    longint m_acc   [2];
    int     m_count [2];
    bit     m_pend  [2];
    longint m_py    [2];
    bit     m_valid [2];
    longint m_data  [2];
    bit     m_ovr   [2];

    function automatic longint clamp16(longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_count[k] = 0; m_pend[k] = 0; m_py[k] = 0;
            m_valid[k] = 0; m_data[k] = 0; m_ovr[k] = 0;
        end
    endtask

    task automatic model_edge(bit inv, longint d, bit en, bit rdy, bit clr, bit r);
        longint x;
        bit     set_ovr;
        if (r) begin
            model_reset();
            return;
        end
        x = d * 256;
        for (int k = 0; k < 2; k++) begin
            set_ovr = 0;
            if (m_pend[k]) begin
                if (!m_valid[k] || rdy) begin
                    m_valid[k] = 1;
                    m_data[k]  = m_py[k];
                end else begin
                    set_ovr = 1;
                end
            end else if (m_valid[k] && rdy) begin
                m_valid[k] = 0;
            end
            if (set_ovr)  m_ovr[k] = 1;
            else if (clr) m_ovr[k] = 0;
            m_pend[k] = 0;
            if (inv) begin
                // Floor of a quarter of the error, i.e. alpha = 1/4.
                if (en) m_acc[k] = m_acc[k] + ((x - m_acc[k]) >>> 2);
                else    m_acc[k] = x;
                m_count[k]++;
                if (m_count[k] == m_decim[k]) begin
                    m_count[k] = 0;
                    m_pend[k]  = 1;
                    m_py[k]    = clamp16(m_acc[k] >>> 8);
                end
            end
        end
    endtask

    task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    task automatic step(bit inv, longint d, bit en, bit rdy, bit clr, bit r);
        rst           = r;
        in_valid_i    = inv;
        data_i        = 32'(d);
        deemph_en_i   = en;
        out_ready_i   = rdy;
        overrun_clr_i = clr;
        @(posedge clk);
        model_edge(inv, d, en, rdy, clr, r);
        #1;
        check("valid_d5",   out_valid_5, m_valid[0]);
        check("data_d5",    data_5,      m_data[0]);
        check("overrun_d5", overrun_5,   m_ovr[0]);
        check("valid_d1",   out_valid_1, m_valid[1]);
        check("data_d1",    data_1,      m_data[1]);
        check("overrun_d1", overrun_1,   m_ovr[1]);
    endtask

    initial begin
        model_reset();
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        check("reset_valid",   out_valid_5, 0);
        check("reset_data",    data_5,      0);
        check("reset_overrun", overrun_5,   0);

        // Step response with de-emphasis active.
        for (int s = 1; s <= 5; s++) begin
            step(1, 1000, 1, 1, 0, 0);
            if (s < 5) for (int i = 0; i < 39; i++) step(0, 1000, 1, 1, 0, 0);
        end
        check("step_latency_early", out_valid_5, 0);
        step(0, 1000, 1, 1, 0, 0);
        check("step_valid", out_valid_5, 1);
        check("step_first", data_5, 762);
        step(0, 0, 1, 1, 0, 0);

        // Bypass ramp with back-to-back strobes.
        for (int i = 1; i <= 15; i++) begin
            step(1, i, 0, 1, 0, 0);
            if (i % 5 == 1 && i > 1) check("ramp_out", data_5, i - 1);
        end
        step(0, 0, 0, 1, 0, 0);
        check("ramp_last", data_5, 15);

        // Saturation in bypass.
        for (int i = 0; i < 5; i++) step(1, 100000, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("sat_pos", data_5, 32767);
        for (int i = 0; i < 5; i++) step(1, -100000, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("sat_neg", data_5, -32768);
        for (int i = 0; i < 5; i++) step(1, -3, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("small_neg", data_5, -3);
        step(0, 0, 0, 1, 1, 0);

        // Backpressure: second decimated sample is dropped.
        for (int i = 0; i < 5; i++) step(1, 111, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 222, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("bp_held_valid", out_valid_5, 1);
        check("bp_held_data",  data_5,      111);
        check("bp_overrun",    overrun_5,   1);
        step(0, 0, 0, 1, 0, 0);
        check("bp_accepted",   out_valid_5, 0);
        check("bp_sticky",     overrun_5,   1);
        step(0, 0, 0, 1, 1, 0);
        check("bp_cleared",    overrun_5,   0);

        // Accept and load on the same edge.
        for (int i = 0; i < 5; i++) step(1, 50, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("sim_first", data_5, 50);
        for (int i = 0; i < 5; i++) step(1, 60, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("sim_valid",   out_valid_5, 1);
        check("sim_data",    data_5,      60);
        check("sim_overrun", overrun_5,   0);
        step(0, 0, 0, 1, 1, 0);

        // Reset mid-stream with a held sample.
        for (int i = 0; i < 5; i++) step(1, 70, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 75, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("rst_valid", out_valid_5, 0);
        check("rst_data",  data_5,      0);
        for (int i = 0; i < 4; i++) step(1, 80, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_no_early", out_valid_5, 0);
        step(1, 80, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_fresh_valid", out_valid_5, 1);
        check("rst_fresh_data",  data_5,      80);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            longint d;
            d = longint'($urandom_range(300000)) - 150000;
            step($urandom_range(1) == 1, d, $urandom_range(3) != 0,
                 $urandom_range(9) < 7, $urandom_range(19) == 0,
                 $urandom_range(499) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
